wb_port_arbiter: RTL and testbench

Shares the single register-file write port between the in-order pipeline writeback stage and the long-latency multiply/divide unit (MDU), which returns results out of order with respect to the pipeline. MDU results that cannot be written immediately are held in a small result buffer. A starvation guard forces the buffer to drain by stalling writeback. A pending-destination scoreboard tells the hazard logic which registers still await an MDU result. Sits between the writeback mux output and the register file.

---
 rtl/rv_wb_pkg.sv | 19 +
 rtl/wb_result_fifo.sv | 61 ++++++
 rtl/wb_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_wb_pkg.sv
// Shared writeback types: request payload and write-port source select.
package rv_wb_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_BUF  = 2'd2,
        SRC_BYP  = 2'd3
    } wb_src_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Small circular FIFO holding MDU results that could not be written on arrival.
module wb_result_fifo
    import rv_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push_i,
    input  wb_req_t                        push_data_i,
    input  logic                           pop_i,
    output wb_req_t                        head_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_req_t            mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between writeback and the MDU,
// with a starvation guard on buffered results and a pending-destination scoreboard.
module wb_port_arbiter
    import rv_wb_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2,
    parameter int unsigned AGE_MAX   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pipe_we,
    input  logic [REG_AW-1:0]   pipe_rd,
    input  logic [XLEN-1:0]     pipe_data,
    output logic                stall_wb,
    input  logic                mdu_valid,
    input  logic [REG_AW-1:0]   mdu_rd,
    input  logic [XLEN-1:0]     mdu_data,
    output logic                mdu_ready,
    input  logic                iss_valid,
    input  logic [REG_AW-1:0]   iss_rd,
    input  logic [REG_AW-1:0]   rs1_addr,
    input  logic [REG_AW-1:0]   rs2_addr,
    output logic                rs1_pending,
    output logic                rs2_pending,
    output logic                rf_we,
    output logic [REG_AW-1:0]   rf_waddr,
    output logic [XLEN-1:0]     rf_wdata
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned AGE_W = 4;
    localparam int unsigned NREG  = 1 << REG_AW;

    logic [CNT_W-1:0]   count;
    wb_req_t            head;
    wb_req_t            mdu_req;
    wb_src_e            src;
    logic               pipe_req, mdu_keep, buf_nonempty, force_drain;
    logic               push, pop;

    logic [AGE_W-1:0]   age_q, age_d;
    logic [NREG-1:0]    pend_q, pend_d;
    logic               rf_we_q, rf_we_d;
    logic [REG_AW-1:0]  rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]    rf_wdata_q, rf_wdata_d;

    assign pipe_req     = pipe_we && (pipe_rd != '0);
    assign buf_nonempty = (count != '0);
    assign mdu_ready    = (count < CNT_W'(BUF_DEPTH));
    // Results to x0 complete the handshake but are dropped here.
    assign mdu_keep     = mdu_valid && mdu_ready && (mdu_rd != '0);
    assign force_drain  = buf_nonempty &&
                          ((count == CNT_W'(BUF_DEPTH)) || (age_q == AGE_W'(AGE_MAX)));
    assign mdu_req      = '{rd: mdu_rd, data: mdu_data};

    // Fixed-priority source select for this cycle's write.
    always_comb begin
        src      = SRC_NONE;
        stall_wb = 1'b0;
        if (force_drain) begin
            src      = SRC_BUF;
            stall_wb = pipe_req;
        end else if (pipe_req) begin
            src = SRC_PIPE;
        end else if (buf_nonempty) begin
            src = SRC_BUF;
        end else if (mdu_keep) begin
            src = SRC_BYP;
        end
    end

    assign push = mdu_keep && (src != SRC_BYP);
    assign pop  = (src == SRC_BUF);

    wb_result_fifo #(
        .DEPTH       (BUF_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (mdu_req),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

    always_comb begin
        rf_we_d    = (src != SRC_NONE);
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        age_d      = age_q;
        pend_d     = pend_q;

        unique case (src)
            SRC_PIPE: begin
                rf_waddr_d = pipe_rd;
                rf_wdata_d = pipe_data;
            end
            SRC_BUF: begin
                rf_waddr_d = head.rd;
                rf_wdata_d = head.data;
            end
            SRC_BYP: begin
                rf_waddr_d = mdu_rd;
                rf_wdata_d = mdu_data;
            end
            default: ;
        endcase

        // Age counts only cycles where the head loses to the pipe.
        if (!buf_nonempty || pop) begin
            age_d = '0;
        end else if ((src == SRC_PIPE) && (age_q != AGE_W'(AGE_MAX))) begin
            age_d = age_q + AGE_W'(1);
        end

        // Clear before set so a same-cycle reissue keeps the bit.
        if (src == SRC_BUF) pend_d[head.rd] = 1'b0;
        if (src == SRC_BYP) pend_d[mdu_rd]  = 1'b0;
        if (iss_valid && (iss_rd != '0)) pend_d[iss_rd] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            age_q      <= '0;
            pend_q     <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            age_q      <= age_d;
            pend_q     <= pend_d;
        end
    end

    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign rs1_pending = pend_q[rs1_addr];
    assign rs2_pending = pend_q[rs2_addr];

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter; expected rf writes are queued per cycle.
module tb_wb_port_arbiter;
    import rv_wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        stall_wb;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_pending, rs2_pending;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    always #5 clk = ~clk;

    wb_port_arbiter #(.BUF_DEPTH(2), .AGE_MAX(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pipe_we     (pipe_we),
        .pipe_rd     (pipe_rd),
        .pipe_data   (pipe_data),
        .stall_wb    (stall_wb),
        .mdu_valid   (mdu_valid),
        .mdu_rd      (mdu_rd),
        .mdu_data    (mdu_data),
        .mdu_ready   (mdu_ready),
        .iss_valid   (iss_valid),
        .iss_rd      (iss_rd),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_pending (rs1_pending),
        .rs2_pending (rs2_pending),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Each cycle's expected write is popped one edge after it was queued.
    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("rf_we", 32'(rf_we), 32'(mon_e.we));
            if (mon_e.we) begin
                check("rf_waddr", 32'(rf_waddr), 32'(mon_e.addr));
                check("rf_wdata", rf_wdata, mon_e.data);
            end
        end
    end

    task automatic idle();
        pipe_we = 1'b0; pipe_rd = '0; pipe_data = '0;
        mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
        iss_valid = 1'b0; iss_rd = '0;
    endtask

    task automatic cyc(input logic we, input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e = '{we: we, addr: a, data: d};
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; rs1_addr = '0; rs2_addr = '0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        check("rst_rf_wdata", rf_wdata, 32'd0);
        check("rst_mdu_ready", 32'(mdu_ready), 32'd1);
        check("rst_stall_wb", 32'(stall_wb), 32'd0);
        cyc(1'b0, '0, '0);

        // Pipe only
        pipe_we = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
        #1 check("pipe_stall", 32'(stall_wb), 32'd0);
        cyc(1'b1, 5'd5, 32'hDEADBEEF);
        idle();
        cyc(1'b0, '0, '0);

        // Bypass with scoreboard
        rs1_addr = 5'd7;
        iss_valid = 1'b1; iss_rd = 5'd7;
        cyc(1'b0, '0, '0);
        idle();
        #1 check("byp_pend_set", 32'(rs1_pending), 32'd1);
        cyc(1'b0, '0, '0);
        mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h12;
        #1 check("byp_pend_hold", 32'(rs1_pending), 32'd1);
        check("byp_ready", 32'(mdu_ready), 32'd1);
        cyc(1'b1, 5'd7, 32'h12);
        idle();
        #1 check("byp_pend_clr", 32'(rs1_pending), 32'd0);
        cyc(1'b0, '0, '0);

        // Buffered result starved by the pipe until the age guard fires
        rs2_addr = 5'd3;
        iss_valid = 1'b1; iss_rd = 5'd3;
        cyc(1'b0, '0, '0);
        idle();
        for (int i = 0; i < 5; i++) begin
            pipe_we = 1'b1; pipe_rd = 5'd10; pipe_data = 32'(100 + i);
            mdu_valid = (i == 0); mdu_rd = 5'd3; mdu_data = 32'h33;
            #1 check("age_stall_lo", 32'(stall_wb), 32'd0);
            check("age_pend", 32'(rs2_pending), 32'd1);
            cyc(1'b1, 5'd10, 32'(100 + i));
        end
        mdu_valid = 1'b0;
        pipe_data = 32'd105;
        #1 check("age_stall_hi", 32'(stall_wb), 32'd1);
        cyc(1'b1, 5'd3, 32'h33);
        #1 check("age_stall_rel", 32'(stall_wb), 32'd0);
        check("age_pend_clr", 32'(rs2_pending), 32'd0);
        cyc(1'b1, 5'd10, 32'd105);
        idle();
        cyc(1'b0, '0, '0);

        // Buffer fills while pipe is busy; forced drain keeps FIFO order
        pipe_we = 1'b1; pipe_rd = 5'd11; pipe_data = 32'd200;
        mdu_valid = 1'b1; mdu_rd = 5'd4; mdu_data = 32'h44;
        cyc(1'b1, 5'd11, 32'd200);
        pipe_data = 32'd201; mdu_rd = 5'd6; mdu_data = 32'h66;
        #1 check("full_ready_1", 32'(mdu_ready), 32'd1);
        cyc(1'b1, 5'd11, 32'd201);
        mdu_valid = 1'b0; pipe_data = 32'd202;
        #1 check("full_ready_0", 32'(mdu_ready), 32'd0);
        check("full_stall", 32'(stall_wb), 32'd1);
        cyc(1'b1, 5'd4, 32'h44);
        #1 check("full_stall_rel", 32'(stall_wb), 32'd0);
        check("full_ready_back", 32'(mdu_ready), 32'd1);
        cyc(1'b1, 5'd11, 32'd202);
        idle();
        cyc(1'b1, 5'd6, 32'h66);
        cyc(1'b0, '0, '0);

        // x0 destinations
        pipe_we = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hBAD;
        cyc(1'b0, '0, '0);
        idle();
        mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_data = 32'hBAD;
        #1 check("x0_ready", 32'(mdu_ready), 32'd1);
        cyc(1'b0, '0, '0);
        pipe_we = 1'b1; pipe_rd = 5'd12; pipe_data = 32'd12;
        cyc(1'b1, 5'd12, 32'd12);
        idle();
        iss_valid = 1'b1; iss_rd = 5'd0;
        cyc(1'b0, '0, '0);
        idle();
        rs1_addr = 5'd0;
        #1 check("x0_pend", 32'(rs1_pending), 32'd0);
        cyc(1'b0, '0, '0);

        // Issue and MDU write of the same register in one cycle
        rs1_addr = 5'd9;
        iss_valid = 1'b1; iss_rd = 5'd9;
        cyc(1'b0, '0, '0);
        mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h99;
        cyc(1'b1, 5'd9, 32'h99);
        idle();
        #1 check("coll_pend", 32'(rs1_pending), 32'd1);
        cyc(1'b0, '0, '0);
        mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h9A;
        cyc(1'b1, 5'd9, 32'h9A);
        idle();
        #1 check("coll_pend_clr", 32'(rs1_pending), 32'd0);
        cyc(1'b0, '0, '0);

        // Reset with a full buffer
        rs1_addr = 5'd13; rs2_addr = 5'd14;
        iss_valid = 1'b1; iss_rd = 5'd13;
        cyc(1'b0, '0, '0);
        iss_rd = 5'd14;
        cyc(1'b0, '0, '0);
        idle();
        pipe_we = 1'b1; pipe_rd = 5'd15; pipe_data = 32'd300;
        mdu_valid = 1'b1; mdu_rd = 5'd13; mdu_data = 32'h13;
        cyc(1'b1, 5'd15, 32'd300);
        pipe_data = 32'd301; mdu_rd = 5'd14; mdu_data = 32'h14;
        cyc(1'b1, 5'd15, 32'd301);
        mdu_valid = 1'b0; pipe_data = 32'd302;
        #1 check("rstf_ready", 32'(mdu_ready), 32'd0);
        check("rstf_stall", 32'(stall_wb), 32'd1);
        check("rstf_pend", 32'(rs1_pending), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rstf_rf_we", 32'(rf_we), 32'd0);
        check("rstf_waddr", 32'(rf_waddr), 32'd0);
        check("rstf_wdata", rf_wdata, 32'd0);
        check("rstf_ready_back", 32'(mdu_ready), 32'd1);
        check("rstf_stall_rel", 32'(stall_wb), 32'd0);
        check("rstf_pend1", 32'(rs1_pending), 32'd0);
        check("rstf_pend2", 32'(rs2_pending), 32'd0);
        cyc(1'b1, 5'd15, 32'd302);
        idle();
        repeat (3) cyc(1'b0, '0, '0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
